// File: rtl/unique_list_streamer.sv
// Captures a sorted unique list of up to nine values in one load.
// Replays the list as a valid/ready stream of indexed beats, then pulses done.
module unique_list_streamer #(
    parameter int WIDTH = 8,
    parameter int SLOTS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [WIDTH-1:0] in8,
    input  logic [WIDTH-1:0] in9,
    input  logic [3:0]       in_count,
    input  logic             load,
    output logic             load_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [3:0]       m_index,
    output logic             m_last,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_slot [SLOTS];
    logic [3:0]       r_cnt;
    logic [3:0]       r_idx;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic [3:0]       r_m_index;
    logic             r_m_last;
    logic             r_done;
    logic             r_busy;

    logic [WIDTH-1:0] w_in [SLOTS];
    logic [3:0]       w_cnt_clamp;
    logic [3:0]       w_next_idx;

    assign w_in[0] = in1;
    assign w_in[1] = in2;
    assign w_in[2] = in3;
    assign w_in[3] = in4;
    assign w_in[4] = in5;
    assign w_in[5] = in6;
    assign w_in[6] = in7;
    assign w_in[7] = in8;
    assign w_in[8] = in9;

    assign w_cnt_clamp = (in_count > 4'(SLOTS)) ? 4'(SLOTS) : in_count;
    assign w_next_idx  = r_idx + 4'd1;

    assign load_ready = (r_state == IDLE);
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_index    = r_m_index;
    assign m_last     = r_m_last;
    assign done       = r_done;
    assign busy       = r_busy;

    // Beat outputs are precomputed one cycle ahead so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= 4'd0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_index <= 4'd0;
            r_m_last  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (load) begin
                        for (int i = 0; i < SLOTS; i++) r_slot[i] <= w_in[i];
                        r_cnt  <= w_cnt_clamp;
                        r_idx  <= 4'd0;
                        r_busy <= 1'b1;
                        if (w_cnt_clamp == 4'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= STREAM;
                            r_m_valid <= 1'b1;
                            r_m_data  <= w_in[0];
                            r_m_index <= 4'd1;
                            r_m_last  <= (w_cnt_clamp == 4'd1);
                        end
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (r_m_last) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_m_valid <= 1'b0;
                            r_m_data  <= '0;
                            r_m_index <= 4'd0;
                            r_m_last  <= 1'b0;
                        end else begin
                            r_idx     <= w_next_idx;
                            r_m_data  <= r_slot[w_next_idx];
                            r_m_index <= w_next_idx + 4'd1;
                            r_m_last  <= (w_next_idx == r_cnt - 4'd1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unique_list_streamer.sv
// Scoreboard bench for unique_list_streamer: the driver queues expected beats,
// a negedge monitor pops and compares every transfer.
module tb_unique_list_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drv [9];
    logic [3:0] in_count = 4'd0;
    logic       load = 1'b0;
    logic       load_ready;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [3:0] m_index;
    logic       m_last;
    logic       done;
    logic       busy;

    int total = 0;
    int bad = 0;
    int exp_done = 0;
    int done_seen = 0;
    int xfers = 0;
    bit mon_en = 1'b0;
    logic [12:0] exp_q [$];

    always #5 clk = ~clk;

    unique_list_streamer #(.WIDTH(8), .SLOTS(9)) dut (
        .clk(clk), .rst(rst),
        .in1(drv[0]), .in2(drv[1]), .in3(drv[2]), .in4(drv[3]), .in5(drv[4]),
        .in6(drv[5]), .in7(drv[6]), .in8(drv[7]), .in9(drv[8]),
        .in_count(in_count), .load(load), .load_ready(load_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last), .done(done), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called one step after a clock edge; load is sampled at the following edge.
    task automatic issue_load(input logic [3:0] cnt, input int npush, input bit exp_dn);
        int n;
        n = (cnt > 4'd9) ? 9 : int'(cnt);
        in_count = cnt;
        load = 1'b1;
        for (int i = 0; i < npush; i++)
            exp_q.push_back({drv[i], 4'(i + 1), (i == n - 1)});
        if (exp_dn) exp_done++;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (k == 100) begin
            total++;
            bad++;
            $display("FAIL %s: still busy after 100 cycles", name);
        end
    endtask

    // Monitor
    initial begin
        logic [12:0] held;
        logic [12:0] e;
        bit hold_pending;
        hold_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (done) done_seen++;
                if (hold_pending && m_valid)
                    chk("hold_stable", {19'd0, m_data, m_index, m_last}, {19'd0, held});
                if (!m_valid)
                    chk("idle_outputs_zero", {19'd0, m_data, m_index, m_last}, 32'd0);
                if (m_valid && m_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {19'd0, m_data, m_index, m_last}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {19'd0, m_data, m_index, m_last}, {19'd0, e});
                    end
                end
                hold_pending = m_valid && !m_ready;
                held = {m_data, m_index, m_last};
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        int x0;
        int d0;
        for (int i = 0; i < 9; i++) drv[i] = 8'h55;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_index", {28'd0, m_index}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Four-entry list, m_ready held high
        drv[0] = 8'h03; drv[1] = 8'h07; drv[2] = 8'h0A; drv[3] = 8'h20;
        m_ready = 1'b1;
        x0 = xfers;
        issue_load(4'd4, 4, 1'b1);
        chk("first_beat_valid", {31'd0, m_valid}, 32'd1);
        chk("first_beat_data", {24'd0, m_data}, 32'h03);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("b2b_index", {28'd0, m_index}, 32'(k));
        end
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_valid_low", {31'd0, m_valid}, 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after_done", {31'd0, load_ready}, 32'd1);
        chk("xfers_4", 32'(xfers - x0), 32'd4);

        // Same list, m_ready toggling
        m_ready = 1'b0;
        x0 = xfers;
        issue_load(4'd4, 4, 1'b1);
        for (int k = 0; k < 40 && busy; k++) begin
            m_ready = ~m_ready;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_idle("toggle_idle");
        chk("toggle_xfers", 32'(xfers - x0), 32'd4);

        // in_count = 0
        d0 = done_seen;
        issue_load(4'd0, 0, 1'b1);
        chk("cnt0_no_valid", {31'd0, m_valid}, 32'd0);
        chk("cnt0_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        chk("cnt0_load_ready", {31'd0, load_ready}, 32'd1);

        // in_count = 15 clamps to 9
        for (int i = 0; i < 9; i++) drv[i] = 8'(8'h10 + 8'(i) * 8'h11);
        x0 = xfers;
        issue_load(4'd15, 9, 1'b1);
        wait_idle("clamp_idle");
        chk("clamp_xfers", 32'(xfers - x0), 32'd9);

        // Load during STREAM must be ignored
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) drv[i] = 8'(8'h21 + 8'(i));
        m_ready = 1'b0;
        x0 = xfers;
        issue_load(4'd5, 5, 1'b1);
        for (int i = 0; i < 9; i++) drv[i] = 8'(8'hC0 + 8'(i));
        in_count = 4'd7;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("ignored_load_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle("ignore_idle");
        chk("ignore_xfers", 32'(xfers - x0), 32'd5);

        // Reset after second transfer of a five-entry list
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) drv[i] = 8'(8'h31 + 8'(i));
        x0 = xfers;
        d0 = done_seen;
        issue_load(4'd5, 2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("midrst_xfers", 32'(xfers - x0), 32'd2);
        rst = 1'b0;

        // Immediate new load: single 0x00 entry
        drv[0] = 8'h00;
        issue_load(4'd1, 1, 1'b1);
        chk("zero_valid", {31'd0, m_valid}, 32'd1);
        chk("zero_beat", {19'd0, m_data, m_index, m_last}, {19'd0, 8'h00, 4'd1, 1'b1});
        wait_idle("zero_idle");
        repeat (2) @(posedge clk);
        #1;

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/unique_list_streamer.md
UNIQUE_LIST_STREAMER -- requirements
Module: unique_list_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every slot and of m_data.
REQ-002 SHALL have parameter SLOTS, default 9, number of parallel input slots; fixed at 9 in this revision.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports in1..in9  input  WIDTH each  unique sorted list; in1 is the smallest value, and slots beyond in_count are don't-care.
REQ-007 SHALL have port in_count  input  4  number of valid leading slots.
REQ-008 SHALL have port load  input  1  request to capture the list.
REQ-009 SHALL have port load_ready  output  1  high when a load is accepted this cycle.
REQ-010 SHALL have port m_valid  output  1  stream beat valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the beat.
REQ-012 SHALL have port m_data  output  WIDTH  current slot value.
REQ-013 SHALL have port m_index  output  4  1-based slot number of the current beat.
REQ-014 SHALL have port m_last  output  1  marks the final beat of the list.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the list is finished.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM and DONE.
REQ-018 SHALL assert load_ready combinationally exactly when state is IDLE.
REQ-019 SHALL, in IDLE with load=1, register in1..in9 into internal slots and register cnt = min(in_count, 9), clamping values 10..15 to 9.
REQ-020 SHALL, on a load accept with clamped cnt=0, go to DONE with no stream beats.
REQ-021 SHALL, on a load accept with clamped cnt>=1, go to STREAM with idx=0.
REQ-022 SHALL ignore load in STREAM and DONE; captured slots SHALL NOT change while busy.
REQ-023 SHALL present the first beat (m_valid=1, m_data=slot1, m_index=1) in the cycle after load acceptance; load-to-first-beat latency is 1 clock.
REQ-024 SHALL, in STREAM, drive m_valid=1, m_data=slot[idx+1], m_index=idx+1, and m_last=(idx==cnt-1).
REQ-025 SHALL treat a beat as transferred when m_valid and m_ready are both high at a rising edge.
REQ-026 SHALL, on a non-last transfer, increment idx.
REQ-027 SHALL, on a last transfer, go to DONE.
REQ-028 SHALL, while m_valid=1 and m_ready=0, hold m_data, m_index and m_last stable.
REQ-029 SHALL sustain back-to-back transfers with m_ready held high at 1 beat/clock, so cnt beats occupy exactly cnt STREAM cycles.
REQ-030 SHALL hold m_valid=0 and m_last=0 outside STREAM; m_data and m_index SHALL be 0 outside STREAM.
REQ-031 SHALL keep DONE for exactly one cycle with done=1, then go to IDLE.
REQ-032 SHALL accept a new load one cycle after the DONE cycle, i.e. the first IDLE cycle.
REQ-033 SHALL be sensitive to m_ready only in STREAM; m_ready SHALL be ignored elsewhere.
REQ-034 SHALL perform no value filtering; the block trusts that the producer's list is sorted and unique, and emits slots verbatim, including 0x00.

Reset
REQ-035 SHALL, on rst=1 at a rising edge, set state=IDLE, idx=0, cnt=0 and all slots to 0.
REQ-036 SHALL hold m_valid=0, m_data=0, m_index=0, m_last=0, done=0, busy=0 and load_ready=1 in the cycle after reset.
REQ-037 SHALL give rst priority over load and over m_ready in the same cycle.
REQ-038 SHALL, on reset mid-STREAM, abandon the list with no done pulse and no further beats.

Verification
REQ-039 Load {03,07,0A,20,...} with in_count=4 and m_ready=1 -> beats 03,07,0A,20 with m_index 1..4 on consecutive cycles, m_last on the 20 beat, done 1 cycle later, then load_ready=1.
REQ-040 Same load, m_ready toggled 0/1 each cycle -> each beat held stable while m_ready=0, and exactly 4 transfers occur.
REQ-041 in_count=0 -> no m_valid, done pulses 1 cycle after the accept; in_count=15 -> exactly 9 beats, m_last on index 9.
REQ-042 load pulsed during STREAM with different data -> ignored, and the original list completes unchanged.
REQ-043 rst asserted after the 2nd transfer of a 5-entry list -> the next cycle shows m_valid=0, busy=0, no done pulse, and a new load is accepted immediately.
REQ-044 in_count=1, in1=0x00 -> a single beat with m_data=00, m_index=1, m_last=1.
